program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding, byte-lane
// layout of instruction words and the default memory address width.
package program_loader_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned LANE_W         = 8;
    localparam int unsigned LANES          = 4;
    localparam logic [1:0]  LANE_FIRST     = 2'd0;
    localparam logic [1:0]  LANE_LAST      = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StCheck,
        StRun,
        StErr
    } state_e;

    // Little-endian placement: lane 0 occupies bits 7:0.
    function automatic logic [31:0] place_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        result[lane*LANE_W +: LANE_W] = data;
        return result;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, little-endian words, XOR checksum.
// Writes words into an external instruction memory and releases the core on success.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    state_e              r_state;
    state_e              w_state_next;

    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_xor;
    logic [23:0]         r_asm;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic                w_accept;
    logic                w_word_done;
    logic                w_last_word;
    logic [31:0]         w_word;

    assign w_accept    = in_valid & in_ready;
    assign w_word_done = (r_byte_idx == LANE_LAST);
    // A count of 0 wraps to all-ones here, which selects the full 2**ADDR_W words.
    assign w_last_word = (r_word_idx == (r_count - ADDR_W'(1)));
    assign w_word      = place_lane({8'h00, r_asm}, r_byte_idx, in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        cpu_reset    = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (w_accept && w_word_done && w_last_word) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = (in_data == r_xor) ? StRun : StErr;
                end
            end
            StRun: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            StErr: begin
                err = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= LANE_FIRST;
            r_xor       <= '0;
            r_asm       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    StIdle: begin
                        r_count    <= ADDR_W'(in_data);
                        r_word_idx <= '0;
                        r_byte_idx <= LANE_FIRST;
                        r_xor      <= '0;
                    end
                    StData: begin
                        r_asm      <= w_word[23:0];
                        r_xor      <= r_xor ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_word_done) begin
                            // Address/data only move on the edge that raises the strobe.
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx;
                            r_mem_wdata <= w_word;
                            r_word_idx  <= r_word_idx + ADDR_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
